// File: rtl/serial_host.sv
// serial_host: UART initiator that sends register read/write frames and collects the read reply byte.
// Defining SERIAL_HOST_TIMEOUT_EN adds a read-response timeout of TIMEOUT_CYCLES clocks.
module serial_host #(
    parameter int CLK_FREQUENCY     = 50_000_000,
    parameter int BAUD              = 115_200,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int DBUS_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES    = 1_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_rnw,
    input  logic [PERIPH_ADDR_WIDTH-1:0] req_periph_addr,
    input  logic [REG_ADDR_WIDTH-1:0]    req_reg_addr,
    input  logic [DBUS_WIDTH-1:0]        req_wdata,
    output logic                         rsp_valid,
    output logic [DBUS_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         txd,
    input  logic                         rxd
);

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
`ifdef SERIAL_HOST_TIMEOUT_EN
    localparam int TO_W         = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_ADDR = 3'd2,
        SEND_DATA = 3'd3,
        WAIT_RSP  = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                         state_r;
    logic                           rnw_r;
    logic [PERIPH_ADDR_WIDTH-1:0]   periph_r;
    logic [REG_ADDR_WIDTH-1:0]      reg_addr_r;
    logic [DBUS_WIDTH-1:0]          wdata_r;
    logic [DBUS_WIDTH:0]            tx_shift_r;
    logic [CNT_W-1:0]               tx_cnt_r;
    logic [3:0]                     tx_bit_r;
    logic                           rx_sync1_r;
    logic                           rx_sync2_r;
    logic                           rx_prev_r;
    logic                           rx_active_r;
    logic [CNT_W-1:0]               rx_cnt_r;
    logic [3:0]                     rx_bit_r;
    logic [DBUS_WIDTH-1:0]          rx_shift_r;
`ifdef SERIAL_HOST_TIMEOUT_EN
    logic [TO_W-1:0]                to_cnt_r;
`endif
    logic                           tx_bit_end_s;
    logic                           rx_phase_end_s;

    function automatic logic [DBUS_WIDTH-1:0] cmd_byte(input logic rnw,
                                                       input logic [PERIPH_ADDR_WIDTH-1:0] periph);
        logic [DBUS_WIDTH-1:0] b;
        b = {DBUS_WIDTH{1'b0}};
        b[PERIPH_ADDR_WIDTH-1:0] = periph;
        b[DBUS_WIDTH-1] = rnw;
        return b;
    endfunction

    function automatic logic [DBUS_WIDTH-1:0] addr_byte(input logic [REG_ADDR_WIDTH-1:0] addr);
        logic [DBUS_WIDTH-1:0] b;
        b = {DBUS_WIDTH{1'b0}};
        b[REG_ADDR_WIDTH-1:0] = addr;
        return b;
    endfunction

    assign tx_bit_end_s   = (tx_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
    // The start bit phase ends at mid-bit; every later phase spans a full bit, landing on mid-bit.
    assign rx_phase_end_s = (rx_bit_r == 4'd0) ? (rx_cnt_r == CNT_W'(HALF_BIT - 1))
                                               : (rx_cnt_r == CNT_W'(CLKS_PER_BIT - 1));

    // Two-flop synchronizer for rxd plus a delayed copy for start-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_prev_r  <= 1'b1;
        end else begin
            rx_sync1_r <= rxd;
            rx_sync2_r <= rx_sync1_r;
            rx_prev_r  <= rx_sync2_r;
        end
    end

    // Transaction FSM with the UART transmitter and the reply receiver.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            rnw_r       <= 1'b0;
            periph_r    <= {PERIPH_ADDR_WIDTH{1'b0}};
            reg_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            wdata_r     <= {DBUS_WIDTH{1'b0}};
            tx_shift_r  <= {(DBUS_WIDTH + 1){1'b1}};
            tx_cnt_r    <= {CNT_W{1'b0}};
            tx_bit_r    <= 4'd0;
            rx_active_r <= 1'b0;
            rx_cnt_r    <= {CNT_W{1'b0}};
            rx_bit_r    <= 4'd0;
            rx_shift_r  <= {DBUS_WIDTH{1'b0}};
`ifdef SERIAL_HOST_TIMEOUT_EN
            to_cnt_r    <= {TO_W{1'b0}};
`endif
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= {DBUS_WIDTH{1'b0}};
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            txd         <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        rnw_r      <= req_rnw;
                        periph_r   <= req_periph_addr;
                        reg_addr_r <= req_reg_addr;
                        wdata_r    <= req_wdata;
                        tx_shift_r <= {1'b1, cmd_byte(req_rnw, req_periph_addr)};
                        tx_cnt_r   <= {CNT_W{1'b0}};
                        tx_bit_r   <= 4'd0;
                        txd        <= 1'b0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= SEND_CMD;
                    end else begin
                        txd        <= 1'b1;
                    end
                end
                SEND_CMD, SEND_ADDR, SEND_DATA: begin
                    if (!tx_bit_end_s) begin
                        tx_cnt_r <= tx_cnt_r + CNT_W'(1);
                    end else if (tx_bit_r != 4'd9) begin
                        tx_cnt_r   <= {CNT_W{1'b0}};
                        txd        <= tx_shift_r[0];
                        tx_shift_r <= {1'b1, tx_shift_r[DBUS_WIDTH:1]};
                        tx_bit_r   <= tx_bit_r + 4'd1;
                    end else begin
                        // Stop bit finished: the next byte's start bit follows with no gap.
                        tx_cnt_r <= {CNT_W{1'b0}};
                        tx_bit_r <= 4'd0;
                        case (state_r)
                            SEND_CMD: begin
                                tx_shift_r <= {1'b1, addr_byte(reg_addr_r)};
                                txd        <= 1'b0;
                                state_r    <= SEND_ADDR;
                            end
                            SEND_ADDR: begin
                                if (rnw_r) begin
                                    txd         <= 1'b1;
                                    rx_active_r <= 1'b0;
`ifdef SERIAL_HOST_TIMEOUT_EN
                                    to_cnt_r    <= {TO_W{1'b0}};
`endif
                                    state_r     <= WAIT_RSP;
                                end else begin
                                    tx_shift_r <= {1'b1, wdata_r};
                                    txd        <= 1'b0;
                                    state_r    <= SEND_DATA;
                                end
                            end
                            SEND_DATA: begin
                                txd       <= 1'b1;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                rsp_rdata <= {DBUS_WIDTH{1'b0}};
                                state_r   <= DONE;
                            end
                            default: begin
                                txd     <= 1'b1;
                                state_r <= IDLE;
                            end
                        endcase
                    end
                end
                WAIT_RSP: begin
                    if (!rx_active_r) begin
                        if (rx_prev_r && !rx_sync2_r) begin
                            rx_active_r <= 1'b1;
                            rx_cnt_r    <= {CNT_W{1'b0}};
                            rx_bit_r    <= 4'd0;
                        end
`ifdef SERIAL_HOST_TIMEOUT_EN
                        else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= {DBUS_WIDTH{1'b0}};
                            state_r   <= DONE;
                        end else begin
                            to_cnt_r  <= to_cnt_r + TO_W'(1);
                        end
`endif
                    end else if (!rx_phase_end_s) begin
                        rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                    end else begin
                        rx_cnt_r <= {CNT_W{1'b0}};
                        if (rx_bit_r == 4'd0) begin
                            // A start bit that is high again at mid-bit was a glitch.
                            if (rx_sync2_r) begin
                                rx_active_r <= 1'b0;
                            end else begin
                                rx_bit_r    <= 4'd1;
                            end
                        end else if (rx_bit_r == 4'd9) begin
                            rx_active_r <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= ~rx_sync2_r;
                            rsp_rdata   <= rx_sync2_r ? rx_shift_r : {DBUS_WIDTH{1'b0}};
                            state_r     <= DONE;
                        end else begin
                            rx_shift_r <= {rx_sync2_r, rx_shift_r[DBUS_WIDTH-1:1]};
                            rx_bit_r   <= rx_bit_r + 4'd1;
                        end
                    end
                end
                DONE: begin
                    rsp_valid   <= 1'b0;
                    rsp_err     <= 1'b0;
                    rsp_rdata   <= {DBUS_WIDTH{1'b0}};
                    rx_active_r <= 1'b0;
                    busy        <= 1'b0;
                    req_ready   <= 1'b1;
                    txd         <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    rsp_valid   <= 1'b0;
                    rx_active_r <= 1'b0;
                    busy        <= 1'b0;
                    req_ready   <= 1'b1;
                    txd         <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_host.sv
// Self-checking bench for serial_host: decodes txd as UART, answers reads on rxd, checks responses.
module tb_serial_host;

    localparam int CPB = 10;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [3:0] req_periph_addr;
    logic [7:0] req_reg_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       txd;
    logic       rxd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } rsp_t;
    rsp_t rq[$];

    serial_host #(
        .CLK_FREQUENCY    (1_000_000),
        .BAUD             (100_000),
        .PERIPH_ADDR_WIDTH(4),
        .REG_ADDR_WIDTH   (8),
        .DBUS_WIDTH       (8),
        .TIMEOUT_CYCLES   (500)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rnw        (req_rnw),
        .req_periph_addr(req_periph_addr),
        .req_reg_addr   (req_reg_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .txd            (txd),
        .rxd            (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with rsp_valid high is logged with its cycle number.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rq.push_back('{rsp_rdata, rsp_err, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int limit);
        for (int n = 0; n < limit && rq.size() == 0; n++) tick();
    endtask

    // Capture one UART byte from txd; every bit must hold for exactly CPB samples.
    task automatic rx_byte(output logic [7:0] b, output bit ok, output int last);
        logic s [100];
        int   n;
        ok = 1'b1;
        b  = 8'h00;
        n  = 0;
        @(negedge clk);
        while (txd !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (txd !== 1'b0) begin
            ok   = 1'b0;
            last = cyc;
            return;
        end
        s[0] = txd;
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            s[k] = txd;
        end
        last = cyc;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                if (s[i*10+j] !== s[i*10+5]) ok = 1'b0;
        if (s[5] !== 1'b0 || s[95] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = s[(i+1)*10+5];
    endtask

    // Drive one UART byte onto rxd with a chosen stop-bit level.
    task automatic drive_rx(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_req(input bit rnw, input logic [3:0] pa, input logic [7:0] ra, input logic [7:0] wd);
        @(negedge clk);
        req_rnw         = rnw;
        req_periph_addr = pa;
        req_reg_addr    = ra;
        req_wdata       = wd;
        req_valid       = 1'b1;
        #1;
        chk("ready_idle", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        chk("ready_after_accept", req_ready, 1'b0);
    endtask

    task automatic check_frame(input bit rnw, input logic [3:0] pa, input logic [7:0] ra,
                               input logic [7:0] wd, output int last);
        logic [7:0] b;
        bit         ok;
        int         expb [3];
        expb[0] = (rnw ? 128 : 0) + int'(pa);
        expb[1] = int'(ra);
        expb[2] = int'(wd);
        for (int i = 0; i < (rnw ? 2 : 3); i++) begin
            rx_byte(b, ok, last);
            chk("tx_frame_ok", ok, 1'b1);
            chk("tx_byte", b, expb[i]);
        end
    endtask

    task automatic run_txn(input bit rnw, input logic [3:0] pa, input logic [7:0] ra, input logic [7:0] wd,
                           input logic [7:0] reply, input bit stop_ok, input bit glitch);
        int   last;
        rsp_t r;
        send_req(rnw, pa, ra, wd);
        check_frame(rnw, pa, ra, wd, last);
        if (rnw) begin
            repeat (3) @(negedge clk);
            if (glitch) begin
                rxd = 1'b0;
                repeat (3) @(negedge clk);
                rxd = 1'b1;
                repeat (20) @(negedge clk);
            end
            drive_rx(reply, stop_ok);
        end
        wait_rsp(300);
        chk("rsp_count", rq.size(), 1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("rsp_rdata", r.rdata, (rnw && stop_ok) ? reply : 8'h00);
            chk("rsp_err", r.err, rnw ? !stop_ok : 1'b0);
            if (!rnw) chk("wr_latency", r.cyc, last + 1);
        end
        tick();
        chk("idle_after_rsp", busy, 1'b0);
    endtask

    initial begin
        int   last;
        rsp_t r;
        bit   rnw;
        bit   stop_ok;

        reset = 1'b0;
        rxd = 1'b1;
        req_valid = 1'b0;
        req_rnw = 1'b0;
        req_periph_addr = 4'h0;
        req_reg_addr = 8'h00;
        req_wdata = 8'h00;
        repeat (3) tick();
        chk("rst_txd", txd, 1'b1);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (3) tick();

        // Write with a back-to-back second request held during DONE.
        send_req(1'b0, 4'h2, 8'h05, 8'hA5);
        begin
            logic [7:0] b;
            bit         ok;
            rx_byte(b, ok, last);
            chk("w_b0", b, 8'h02);
            rx_byte(b, ok, last);
            chk("w_b1", b, 8'h05);
            req_rnw = 1'b0; req_periph_addr = 4'h3; req_reg_addr = 8'h22; req_wdata = 8'h5A;
            req_valid = 1'b1;
            rx_byte(b, ok, last);
            chk("w_b2", b, 8'hA5);
            chk("w_frame_ok", ok, 1'b1);
        end
        tick();
        chk("done_rsp_valid", rsp_valid, 1'b1);
        chk("done_ready", req_ready, 1'b0);
        chk("done_busy", busy, 1'b1);
        tick();
        chk("idle_ready", req_ready, 1'b1);
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("second_accept_busy", busy, 1'b1);
        chk("w_rsp_count", rq.size(), 1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("w_latency", r.cyc, last + 1);
            chk("w_err", r.err, 1'b0);
            chk("w_rdata", r.rdata, 8'h00);
        end
        check_frame(1'b0, 4'h3, 8'h22, 8'h5A, last);
        wait_rsp(50);
        chk("w2_rsp_count", rq.size(), 1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("w2_latency", r.cyc, last + 1);
        end
        repeat (2) tick();

        // Directed reads: good reply, framing error, glitch before a valid reply.
        run_txn(1'b1, 4'h1, 8'h10, 8'h00, 8'h3C, 1'b1, 1'b0);
        run_txn(1'b1, 4'h1, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b0);
        run_txn(1'b1, 4'h6, 8'h20, 8'h00, 8'h55, 1'b1, 1'b1);

        // A byte on rxd while idle must not produce any response.
        drive_rx(8'hAA, 1'b1);
        repeat (5) tick();
        chk("rx_ignored_idle", rq.size(), 0);
        chk("rx_ignored_busy", busy, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 8; t++) begin
            rnw     = 1'($urandom_range(0, 1));
            stop_ok = ($urandom_range(0, 3) != 0);
            run_txn(rnw, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), stop_ok, 1'b0);
        end

        // Read with no reply.
        send_req(1'b1, 4'h7, 8'h33, 8'h00);
        check_frame(1'b1, 4'h7, 8'h33, 8'h00, last);
`ifdef SERIAL_HOST_TIMEOUT_EN
        wait_rsp(700);
        chk("to_rsp_count", rq.size(), 1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("to_cycle", r.cyc, last + 501);
            chk("to_err", r.err, 1'b1);
            chk("to_rdata", r.rdata, 8'h00);
        end
`else
        repeat (600) tick();
        chk("no_to_busy", busy, 1'b1);
        chk("no_to_rsp", rq.size(), 0);
`endif
        reset = 1'b0;
        #1;
        chk("rst_wait_busy", busy, 1'b0);
        chk("rst_wait_ready", req_ready, 1'b1);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Reset in the middle of byte1 of a write aborts it silently.
        send_req(1'b0, 4'h4, 8'h99, 8'h11);
        begin
            logic [7:0] b;
            bit         ok;
            rx_byte(b, ok, last);
            chk("abort_b0", b, 8'h04);
        end
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_txd", txd, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", req_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (400) tick();
        chk("abort_no_rsp", rq.size(), 0);
        chk("abort_txd_idle", txd, 1'b1);
        run_txn(1'b0, 4'h9, 8'h44, 8'hC3, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_host.md
SERIAL_HOST -- requirements
Module: serial_host

Interface
REQ-001 SHALL provide parameter CLK_FREQUENCY, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115_200, meaning the UART bit rate; CLKS_PER_BIT = CLK_FREQUENCY/BAUD, integer truncation.
REQ-003 SHALL provide parameter PERIPH_ADDR_WIDTH, default 4, meaning the peripheral address width (max 7).
REQ-004 SHALL provide parameter REG_ADDR_WIDTH, default 8, meaning the register address width (max 8).
REQ-005 SHALL provide parameter DBUS_WIDTH, default 8, meaning the data width (fixed 8).
REQ-006 SHALL provide parameter TIMEOUT_CYCLES, default 1_000_000, meaning the read-response timeout in clk cycles.
REQ-007 Ports, in order:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_rnw  in  1  1=read, 0=write
- req_periph_addr  in  PERIPH_ADDR_WIDTH  target peripheral
- req_reg_addr  in  REG_ADDR_WIDTH  target register
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  error flag, valid with rsp_valid
- busy  out  1  transaction in progress
- txd  out  1  UART serial out, idle high
- rxd  in  1  UART serial in, asynchronous

Function
REQ-008 SHALL be the host/initiator end of the serial register protocol: it issues frames that the FPGA-side serial master decodes.
REQ-009 Frame: byte0 = {rnw, zero pad, periph_addr} (rnw in bit 7); byte1 = reg_addr, zero-extended; byte2 = wdata, writes only; read response = one data byte on rxd.
REQ-010 UART format SHALL be 8N1, LSB first, each bit held exactly CLKS_PER_BIT cycles; bytes sent back-to-back, no idle gap.
REQ-011 req_ready SHALL be high only in IDLE; a handshake latches all req_* fields into internal registers in the same cycle.
REQ-012 FSM states: IDLE -> SEND_CMD -> SEND_ADDR -> (write) SEND_DATA -> DONE, or (read) WAIT_RSP -> DONE; DONE -> IDLE unconditionally after one cycle.
REQ-013 Write SHALL complete in DONE one cycle after the stop bit of byte2 ends: rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-014 Receiver SHALL pass rxd through a 2-flop synchronizer, detect the falling start edge, recheck low at mid start bit (glitch -> discard), and sample each data bit at mid-bit.
REQ-015 Receiver SHALL be enabled only in WAIT_RSP; any rxd activity in other states SHALL be ignored.
REQ-016 A read received with a valid (high) stop bit SHALL go to DONE: rsp_valid=1, rsp_rdata=byte, rsp_err=0.
REQ-017 A stop bit sampled low (framing error) SHALL go to DONE: rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-018 busy SHALL be high in every state except IDLE.
REQ-019 A req_valid held high during DONE SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-020 reset low SHALL asynchronously force IDLE, txd=1, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, and clear all counters and synchronizer flops to 1.
REQ-021 Reset mid-frame SHALL abort the frame immediately; no rsp_valid SHALL be produced for the aborted request.

Configuration
REQ-022 With macro SERIAL_HOST_TIMEOUT_EN defined, a counter SHALL run in WAIT_RSP; reaching TIMEOUT_CYCLES with no start bit detected SHALL go to DONE with rsp_err=1, rsp_rdata=0; a detected start bit freezes the counter.
REQ-023 With SERIAL_HOST_TIMEOUT_EN undefined, no timeout logic SHALL exist and WAIT_RSP SHALL wait indefinitely.

Verification (CLK_FREQUENCY=1_000_000, BAUD=100_000 -> 10 clks/bit, TIMEOUT_CYCLES=500)
REQ-024 Write periph 2, reg 0x05, data 0xA5 -> txd carries 0x02,0x05,0xA5 (300 cycles); rsp_valid with rsp_err=0 one cycle after the final stop bit.
REQ-025 Read periph 1, reg 0x10; bench replies 0x3C -> txd carries 0x81,0x10; rsp_valid, rsp_rdata=0x3C, rsp_err=0.
REQ-026 Read; bench replies 0x3C with stop bit low -> rsp_valid, rsp_err=1, rsp_rdata=0x00.
REQ-027 Read with no reply, macro defined -> rsp_err=1 exactly 500 cycles after entering WAIT_RSP; macro undefined -> busy remains high.
REQ-028 Assert reset for 2 cycles during byte1 of a write -> txd=1 immediately, no rsp_valid; a following request completes normally.
REQ-029 Drive a 3-cycle low glitch on rxd in WAIT_RSP, then a valid 0x55 -> glitch ignored, rsp_rdata=0x55.
